pkt_meta_dispatcher: RTL

- Sits between the metadata buffer and the packet queue managers, in place of the combinational steering logic in the PCIe top.
- Steers each pkt_meta_t to packet queue manager (QM) pkt_queue_id[QM_ID_W-1:0] through a 2-entry per-QM buffer.
- In parallel, emits the chosen QM id on a buffered order stream, which feeds st_ordered_multiplexer so descriptor-queue order matches arrival order.
- Counts back-pressure stall cycles for software.

---
 rtl/pkt_meta_dispatcher_pkg.sv | 32 +++
 rtl/pkt_meta_dispatcher_sync_fifo.sv | 54 +++++
 rtl/pkt_meta_dispatcher.sv | 106 ++++++++++
 3 files changed

// File: rtl/pkt_meta_dispatcher_pkg.sv
// Shared metadata types and QM sizing for the packet metadata dispatcher.
// The steering copy from pkt_meta_t to pkt_meta_with_queues_t lives here too.
package pkt_meta_dispatcher_pkg;

  localparam int NB_PKT_QUEUE_MANAGERS = 4;
  localparam int PKT_QM_ID_WIDTH = (NB_PKT_QUEUE_MANAGERS > 1) ? $clog2(NB_PKT_QUEUE_MANAGERS) : 1;

  localparam int DSC_QUEUE_ID_W = 12;
  localparam int PKT_QUEUE_ID_W = 12;
  localparam int PKT_SIZE_W     = 16;

  typedef struct packed {
    logic [DSC_QUEUE_ID_W-1:0] dsc_queue_id;
    logic [PKT_QUEUE_ID_W-1:0] pkt_queue_id;
    logic [PKT_SIZE_W-1:0]     size;
  } pkt_meta_t;

  typedef struct packed {
    logic [DSC_QUEUE_ID_W-1:0] dsc_queue_id;
    logic [PKT_QUEUE_ID_W-1:0] pkt_queue_id;
    logic [PKT_SIZE_W-1:0]     size;
  } pkt_meta_with_queues_t;

  function automatic pkt_meta_with_queues_t to_meta_with_queues(input pkt_meta_t m);
    pkt_meta_with_queues_t r;
    r.dsc_queue_id = m.dsc_queue_id;
    r.pkt_queue_id = m.pkt_queue_id;
    r.size         = m.size;
    return r;
  endfunction

endpackage

// File: rtl/pkt_meta_dispatcher_sync_fifo.sv
// Small synchronous FIFO whose head is always driven from storage registers,
// so data is stable while the consumer stalls. DEPTH must be a power of two >= 2.
module sync_fifo_reg_out #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     in_valid,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occup
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       cnt_reg;
  logic              push;
  logic              pop;

  assign push      = in_valid && (cnt_reg != FULL);
  assign pop       = out_valid && out_ready;
  assign out_valid = (cnt_reg != '0);
  assign out_data  = mem[rd_ptr_reg];
  assign occup     = cnt_reg;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_data;
  end

endmodule

// File: rtl/pkt_meta_dispatcher.sv
// Steers packet metadata to per-QM 2-entry buffers and records the chosen QM
// on an order stream so downstream muxing can restore arrival order.
module pkt_meta_dispatcher
  import pkt_meta_dispatcher_pkg::*;
#(
  parameter int NB_QM       = NB_PKT_QUEUE_MANAGERS,
  parameter int QM_ID_W     = (NB_QM > 1) ? $clog2(NB_QM) : 1,
  parameter int ORDER_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sw_reset,
  input  pkt_meta_t                     in_meta_data,
  input  logic                          in_meta_valid,
  output logic                          in_meta_ready,
  output pkt_meta_with_queues_t         out_meta_data [NB_QM],
  output logic                          out_meta_valid [NB_QM],
  input  logic                          out_meta_ready [NB_QM],
  output logic [QM_ID_W-1:0]            order_data,
  output logic                          order_valid,
  input  logic                          order_ready,
  output logic [$clog2(ORDER_DEPTH):0]  order_occup,
  output logic [31:0]                   stall_cnt
);

  localparam int META_W = $bits(pkt_meta_with_queues_t);
  localparam int OCW    = $clog2(ORDER_DEPTH) + 1;
  localparam logic [OCW-1:0] ORDER_FULL = OCW'(ORDER_DEPTH);

  logic [QM_ID_W-1:0]    tgt;
  logic [1:0]            qcnt [NB_QM];
  logic [1:0]            tgt_cnt;
  logic                  acc;
  pkt_meta_with_queues_t in_meta_q;
  logic [31:0]           stall_cnt_reg;

  generate
    if (NB_QM > 1) begin : g_tgt_multi
      assign tgt = in_meta_data.pkt_queue_id[QM_ID_W-1:0];
    end else begin : g_tgt_single
      assign tgt = '0;
    end
  endgenerate

  always_comb begin
    tgt_cnt = '0;
    for (int i = 0; i < NB_QM; i++) begin
      if (tgt == QM_ID_W'(i)) tgt_cnt = qcnt[i];
    end
  end

  // Ready looks only at registered fill levels, never at downstream readies.
  assign in_meta_ready = (tgt_cnt < 2'd2) && (order_occup != ORDER_FULL);
  assign acc           = in_meta_valid && in_meta_ready;
  assign in_meta_q     = to_meta_with_queues(in_meta_data);

  generate
    for (genvar gi = 0; gi < NB_QM; gi++) begin : g_qm
      logic [META_W-1:0] qm_out_data;

      sync_fifo_reg_out #(
        .DWIDTH (META_W),
        .DEPTH  (2)
      ) u_qm_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_meta_q),
        .in_valid  (acc && (tgt == QM_ID_W'(gi))),
        .out_data  (qm_out_data),
        .out_valid (out_meta_valid[gi]),
        .out_ready (out_meta_ready[gi]),
        .occup     (qcnt[gi])
      );

      assign out_meta_data[gi] = qm_out_data;
    end
  endgenerate

  sync_fifo_reg_out #(
    .DWIDTH (QM_ID_W),
    .DEPTH  (ORDER_DEPTH)
  ) u_order_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (tgt),
    .in_valid  (acc),
    .out_data  (order_data),
    .out_valid (order_valid),
    .out_ready (order_ready),
    .occup     (order_occup)
  );

  // Software-visible stall counter; sw_reset clears it without touching the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (sw_reset) begin
      stall_cnt_reg <= '0;
    end else if (in_meta_valid && !in_meta_ready && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
